ihex_ram_loader: RTL and testbench
==================================

Name: ihex_ram_loader

Overview:
- Writer-side companion to the on-chip boot/monitor ROM. Parses an Intel HEX ASCII byte stream, typically from the UART RX, and writes the decoded data into the single-port RAM that shadows or replaces the ROM image.
- Lets a new monitor or CP/M image be loaded at runtime without regenerating the init file.
- Sits between the UART receive byte interface and the RAM write port. It runs in the same clock domain as the RAM.

Parameters:
- ADDR_WIDTH, 14, RAM address width. Loadable range is 0 to 2**ADDR_WIDTH-1.
- DATA_WIDTH, 8, RAM data width. Fixed at 8; any other value is a synthesis error.

Ports:
- clock  in  1  system clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high; clears all state and outputs.
- in_valid  in  1  one-cycle strobe; in_byte is valid this cycle.
- in_byte  in  8  ASCII character from the receiver.
- restart  in  1  one-cycle strobe; returns the FSM to WAIT_COLON and clears done, error, err_code and rec_count.
- wr_en  out  1  RAM write strobe, one cycle per data byte.
- wr_addr  out  ADDR_WIDTH  RAM write address.
- wr_data  out  8  RAM write data.
- done  out  1  sticky; a valid EOF record was received.
- error  out  1  sticky; the parse failed.
- err_code  out  2  error cause: 1 = bad character, 2 = checksum, 3 = address out of range.
- rec_count  out  16  count of records that passed their checksum; saturates at FFFF.

Behaviour:
- Reset values: wr_en=0, wr_addr=0, wr_data=0, done=0, error=0, err_code=0, rec_count=0, state=WAIT_COLON.
- Bytes are consumed only when in_valid=1. There is no backpressure; one byte is accepted per in_valid.
- Hex digits 0-9, A-F and a-f are accepted.
- FSM states:
  - WAIT_COLON: ':' clears the checksum accumulator and the nibble counter, then goes to LEN. All other characters (CR, LF, space, etc.) are ignored.
  - LEN: 2 nibbles giving len.
  - ADDR: 4 nibbles, big-endian, giving the 16-bit load address.
  - TYPE: 2 nibbles.
  - DATA: 2*len nibbles. Skipped when len=0.
  - CSUM: 2 nibbles.
  - DONE and ERR: terminal. Input is ignored until restart or reset.
- In any field state, a non-hex character (including ':') goes to ERR with err_code=1.
- Checksum: 8-bit sum, modulo 256, of every byte from LEN through CSUM. It must equal 0.
  - On the cycle the second CSUM nibble is accepted, a zero sum increments rec_count.
  - A nonzero sum goes to ERR with err_code=2.
- Record types:
  - 00: data record.
  - 01: EOF. With a good checksum it goes to DONE and sets done. A nonzero len on EOF is ignored.
  - Any other type: data is parsed and checksummed but not written.
- Data writes:
  - When the second nibble of a data byte is accepted in cycle N, wr_en=1 in cycle N+1 with the assembled byte on wr_data and the current load address on wr_addr.
  - The address then increments modulo 2**16.
  - Writes are streamed, so a later checksum error does not retract bytes already written.
- Range check: if a type-00 byte's 16-bit address has any bit set at or above ADDR_WIDTH, the write is suppressed and the FSM goes to ERR with err_code=3. This check is done in the same cycle as the second nibble.
- error=1 whenever state is ERR; err_code holds the first cause until restart.
- Simultaneous events:
  - reset overrides everything.
  - restart in the same cycle as in_valid: restart wins and the byte is discarded.
  - restart on the same cycle a write is due: the pending wr_en is still issued.
- Reset mid-record abandons the record. No partial write is issued after reset is asserted.

Decomposition:
- Package ihex_pkg contains:
  - the state enum;
  - ASCII constants (':', CR, LF);
  - record type constants REC_DATA=8'h00 and REC_EOF=8'h01;
  - error code constants ERR_NONE, ERR_CHAR, ERR_CSUM, ERR_RANGE.
- One sub-module, ihex_nibble_decode: combinational, takes an ASCII character and returns a 4-bit nibble plus an is_hex flag. It is instantiated once.

Test Plan:
- ":02001000ABCD76" + CRLF -> wr_en pulses with AB@0x0010 then CD@0x0011, each one cycle after its second nibble; rec_count=1; error=0.
- The record above followed by ":00000001ff" (lowercase) -> done=1, rec_count=2; bytes sent after that produce no writes.
- ":02001000ABCD77" -> both writes occur, then error=1, err_code=2, rec_count=0.
- ":02G0" -> error=1 and err_code=1 on the 'G' cycle; no wr_en.
- With ADDR_WIDTH=14, ":01400000AA15" -> no wr_en, error=1, err_code=3. Then a restart pulse clears error, and ":02001000ABCD76" loads normally.
- ":0200" followed by a one-cycle reset, then ":02001000ABCD76" -> only the two correct writes occur and rec_count=1.

Source files
------------

// File: rtl/ihex_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ihex_pkg
// Brief   : Shared state encoding, ASCII and record constants for the loader.
// Revision: 1.0
// ============================================================================
package ihex_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_WAIT_COLON = 3'd0;
    localparam state_t ST_LEN        = 3'd1;
    localparam state_t ST_ADDR       = 3'd2;
    localparam state_t ST_TYPE       = 3'd3;
    localparam state_t ST_DATA       = 3'd4;
    localparam state_t ST_CSUM       = 3'd5;
    localparam state_t ST_DONE       = 3'd6;
    localparam state_t ST_ERR        = 3'd7;

    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    localparam logic [7:0] REC_DATA = 8'h00;
    localparam logic [7:0] REC_EOF  = 8'h01;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_CHAR  = 2'd1;
    localparam logic [1:0] ERR_CSUM  = 2'd2;
    localparam logic [1:0] ERR_RANGE = 2'd3;

endpackage
`default_nettype wire

// File: rtl/ihex_nibble_decode.sv
`default_nettype none
// ============================================================================
// Module  : ihex_nibble_decode
// Brief   : ASCII hex digit (0-9, A-F, a-f) to 4-bit nibble with a valid flag.
// Revision: 1.0
// ============================================================================
module ihex_nibble_decode (
    input  logic [7:0] i_char,
    output logic [3:0] o_nibble,
    output logic       o_is_hex
);

    always_comb begin
        o_nibble = 4'd0;
        o_is_hex = 1'b0;
        if (i_char >= 8'h30 && i_char <= 8'h39) begin
            o_nibble = i_char[3:0];
            o_is_hex = 1'b1;
        end else if ((i_char >= 8'h41 && i_char <= 8'h46) ||
                     (i_char >= 8'h61 && i_char <= 8'h66)) begin
            // 'A'/'a' have low nibble 1, so +9 yields 10..15
            o_nibble = i_char[3:0] + 4'd9;
            o_is_hex = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ihex_ram_loader.sv
`default_nettype none
// ============================================================================
// Module  : ihex_ram_loader
// Brief   : Streams Intel HEX records from a byte source into a RAM write port.
// Revision: 1.0
// ============================================================================
module ihex_ram_loader
    import ihex_pkg::*;
#(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [7:0]            in_byte,
    input  logic                  restart,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            err_code,
    output logic [15:0]           rec_count
);

    if (DATA_WIDTH != 8) begin : g_bad_data_width
        $error("ihex_ram_loader: DATA_WIDTH must be 8");
    end
    if (ADDR_WIDTH < 1 || ADDR_WIDTH > 16) begin : g_bad_addr_width
        $error("ihex_ram_loader: ADDR_WIDTH must be 1..16");
    end

    state_t                r_state;
    logic [1:0]            r_nib_cnt;
    logic [3:0]            r_hi;
    logic [7:0]            r_len;
    logic [7:0]            r_type;
    logic [7:0]            r_left;
    logic [7:0]            r_csum;
    logic [15:0]           r_addr;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [7:0]            r_wr_data;
    logic                  r_done;
    logic [1:0]            r_err_code;
    logic [15:0]           r_rec_count;

    logic [3:0] w_nibble;
    logic       w_is_hex;
    logic [7:0] w_byte;
    logic [7:0] w_csum_next;
    logic       w_in_field;
    logic       w_byte_done;
    logic       w_oob;

    ihex_nibble_decode u_nibble_decode (
        .i_char   (in_byte),
        .o_nibble (w_nibble),
        .o_is_hex (w_is_hex)
    );

    assign w_byte      = {r_hi, w_nibble};
    assign w_csum_next = r_csum + w_byte;
    assign w_in_field  = (r_state >= ST_LEN) && (r_state <= ST_CSUM);
    // Odd nibble count means this digit completes a byte in every field
    assign w_byte_done = r_nib_cnt[0];
    assign w_oob       = (r_addr >> ADDR_WIDTH) != 16'd0;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_WAIT_COLON;
            r_nib_cnt   <= 2'd0;
            r_hi        <= 4'd0;
            r_len       <= 8'd0;
            r_type      <= 8'd0;
            r_left      <= 8'd0;
            r_csum      <= 8'd0;
            r_addr      <= 16'd0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= 8'd0;
            r_done      <= 1'b0;
            r_err_code  <= ERR_NONE;
            r_rec_count <= 16'd0;
        end else begin
            r_wr_en <= 1'b0;
            if (restart) begin
                r_state     <= ST_WAIT_COLON;
                r_nib_cnt   <= 2'd0;
                r_done      <= 1'b0;
                r_err_code  <= ERR_NONE;
                r_rec_count <= 16'd0;
            end else if (in_valid) begin
                if (r_state == ST_WAIT_COLON) begin
                    if (in_byte == ASCII_COLON) begin
                        r_csum    <= 8'd0;
                        r_nib_cnt <= 2'd0;
                        r_state   <= ST_LEN;
                    end
                end else if (w_in_field) begin
                    if (!w_is_hex) begin
                        r_state    <= ST_ERR;
                        r_err_code <= ERR_CHAR;
                    end else begin
                        r_hi <= w_nibble;
                        // ADDR keeps counting through its four digits
                        r_nib_cnt <= (w_byte_done && r_state != ST_ADDR) ? 2'd0 : r_nib_cnt + 2'd1;
                        if (r_state == ST_ADDR)
                            r_addr <= {r_addr[11:0], w_nibble};
                        if (w_byte_done) begin
                            r_csum <= w_csum_next;
                            case (r_state)
                                ST_LEN: begin
                                    r_len   <= w_byte;
                                    r_state <= ST_ADDR;
                                end
                                ST_ADDR: begin
                                    if (r_nib_cnt == 2'd3)
                                        r_state <= ST_TYPE;
                                end
                                ST_TYPE: begin
                                    r_type  <= w_byte;
                                    r_left  <= r_len;
                                    r_state <= (r_len == 8'd0) ? ST_CSUM : ST_DATA;
                                end
                                ST_DATA: begin
                                    r_left <= r_left - 8'd1;
                                    r_addr <= r_addr + 16'd1;
                                    if (r_left == 8'd1)
                                        r_state <= ST_CSUM;
                                    if (r_type == REC_DATA) begin
                                        if (w_oob) begin
                                            r_state    <= ST_ERR;
                                            r_err_code <= ERR_RANGE;
                                        end else begin
                                            r_wr_en   <= 1'b1;
                                            r_wr_addr <= r_addr[ADDR_WIDTH-1:0];
                                            r_wr_data <= w_byte;
                                        end
                                    end
                                end
                                default: begin
                                    if (w_csum_next == 8'd0) begin
                                        if (r_rec_count != 16'hFFFF)
                                            r_rec_count <= r_rec_count + 16'd1;
                                        if (r_type == REC_EOF) begin
                                            r_state <= ST_DONE;
                                            r_done  <= 1'b1;
                                        end else begin
                                            r_state <= ST_WAIT_COLON;
                                        end
                                    end else begin
                                        r_state    <= ST_ERR;
                                        r_err_code <= ERR_CSUM;
                                    end
                                end
                            endcase
                        end
                    end
                end
            end
        end
    end

    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign done      = r_done;
    assign error     = (r_state == ST_ERR);
    assign err_code  = r_err_code;
    assign rec_count = r_rec_count;

endmodule
`default_nettype wire

// File: tb/tb_ihex_ram_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_ihex_ram_loader
// Brief   : Directed self-checking bench for the Intel HEX RAM loader.
// Revision: 1.0
// ============================================================================
module tb_ihex_ram_loader;
    import ihex_pkg::*;

    localparam int AW = 14;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [7:0]    in_byte;
    logic          restart;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          done;
    logic          error;
    logic [1:0]    err_code;
    logic [15:0]   rec_count;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] log_addr[$];
    logic [7:0]    log_data[$];

    ihex_ram_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_byte   (in_byte),
        .restart   (restart),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .done      (done),
        .error     (error),
        .err_code  (err_code),
        .rec_count (rec_count)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (wr_en === 1'b1) begin
            log_addr.push_back(wr_addr);
            log_data.push_back(wr_data);
        end
    end

    // Each call consumes one clock; on return the edge that accepted c has passed
    task automatic send_char(input logic [7:0] c);
        in_valid = 1'b1;
        in_byte  = c;
        @(negedge clock);
        in_valid = 1'b0;
        in_byte  = 8'h00;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++)
            send_char(s.getc(i));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(negedge clock);
        restart = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        checks++;
        if ({wr_en, wr_addr, wr_data} !== '0) begin
            errors++;
            $display("FAIL reset_wr: got en=%0b addr=%h data=%h expected all zero", wr_en, wr_addr, wr_data);
        end
        checks++;
        if ({done, error, err_code} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got done=%0b error=%0b code=%0d expected 0/0/0", done, error, err_code);
        end
        checks++;
        if (rec_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d expected 0", rec_count);
        end
    endtask

    task automatic test_data_record();
        int base;
        base = log_addr.size();
        send_str(":02001000A");
        checks++;
        if (wr_en !== 1'b0) begin
            errors++;
            $display("FAIL rec_early_wr: got wr_en=%0b expected 0", wr_en);
        end
        send_char("B");
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 14'h0010 || wr_data !== 8'hAB) begin
            errors++;
            $display("FAIL rec_wr0: got en=%0b addr=%h data=%h expected 1/0010/ab", wr_en, wr_addr, wr_data);
        end
        send_char("C");
        checks++;
        if (wr_en !== 1'b0) begin
            errors++;
            $display("FAIL rec_gap: got wr_en=%0b expected 0", wr_en);
        end
        send_char("D");
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 14'h0011 || wr_data !== 8'hCD) begin
            errors++;
            $display("FAIL rec_wr1: got en=%0b addr=%h data=%h expected 1/0011/cd", wr_en, wr_addr, wr_data);
        end
        send_str("76");
        checks++;
        if (rec_count !== 16'd1 || error !== 1'b0) begin
            errors++;
            $display("FAIL rec_csum_ok: got count=%0d error=%0b expected 1/0", rec_count, error);
        end
        send_char(ASCII_CR);
        send_char(ASCII_LF);
        idle(2);
        checks++;
        if (log_addr.size() - base != 2) begin
            errors++;
            $display("FAIL rec_wr_total: got %0d writes expected 2", log_addr.size() - base);
        end
    endtask

    task automatic test_eof();
        int base;
        send_str(":00000001ff");
        idle(1);
        checks++;
        if (done !== 1'b1 || rec_count !== 16'd2 || error !== 1'b0) begin
            errors++;
            $display("FAIL eof: got done=%0b count=%0d error=%0b expected 1/2/0", done, rec_count, error);
        end
        base = log_addr.size();
        send_str(":01000000AA55");
        idle(2);
        checks++;
        if (log_addr.size() - base != 0 || done !== 1'b1 || rec_count !== 16'd2) begin
            errors++;
            $display("FAIL eof_ignore: got writes=%0d done=%0b count=%0d expected 0/1/2",
                     log_addr.size() - base, done, rec_count);
        end
    endtask

    task automatic test_csum_error();
        int base;
        pulse_restart();
        checks++;
        if (done !== 1'b0 || rec_count !== 16'd0) begin
            errors++;
            $display("FAIL restart_clear: got done=%0b count=%0d expected 0/0", done, rec_count);
        end
        base = log_addr.size();
        send_str(":02001000ABCD77");
        idle(1);
        checks++;
        if (log_addr.size() - base != 2) begin
            errors++;
            $display("FAIL csum_streamed: got %0d writes expected 2", log_addr.size() - base);
        end else begin
            checks++;
            if (log_addr[base] !== 14'h0010 || log_data[base] !== 8'hAB ||
                log_addr[base+1] !== 14'h0011 || log_data[base+1] !== 8'hCD) begin
                errors++;
                $display("FAIL csum_wr_vals: got %h@%h %h@%h expected ab@0010 cd@0011",
                         log_data[base], log_addr[base], log_data[base+1], log_addr[base+1]);
            end
        end
        checks++;
        if (error !== 1'b1 || err_code !== ERR_CSUM || rec_count !== 16'd0) begin
            errors++;
            $display("FAIL csum_err: got error=%0b code=%0d count=%0d expected 1/2/0", error, err_code, rec_count);
        end
    endtask

    task automatic test_bad_char();
        int base;
        pulse_restart();
        base = log_addr.size();
        send_str(":02");
        send_char("G");
        checks++;
        if (error !== 1'b1 || err_code !== ERR_CHAR) begin
            errors++;
            $display("FAIL bad_char: got error=%0b code=%0d expected 1/1", error, err_code);
        end
        send_str("00");
        idle(2);
        checks++;
        if (log_addr.size() - base != 0 || err_code !== ERR_CHAR) begin
            errors++;
            $display("FAIL bad_char_hold: got writes=%0d code=%0d expected 0/1", log_addr.size() - base, err_code);
        end
    endtask

    task automatic test_range();
        int base;
        pulse_restart();
        base = log_addr.size();
        send_str(":01400000AA15");
        idle(2);
        checks++;
        if (log_addr.size() - base != 0 || error !== 1'b1 || err_code !== ERR_RANGE) begin
            errors++;
            $display("FAIL range: got writes=%0d error=%0b code=%0d expected 0/1/3",
                     log_addr.size() - base, error, err_code);
        end
        pulse_restart();
        checks++;
        if (error !== 1'b0 || err_code !== ERR_NONE) begin
            errors++;
            $display("FAIL range_restart: got error=%0b code=%0d expected 0/0", error, err_code);
        end
        base = log_addr.size();
        send_str(":02001000ABCD76");
        idle(1);
        checks++;
        if (log_addr.size() - base != 2 || rec_count !== 16'd1 || error !== 1'b0) begin
            errors++;
            $display("FAIL range_reload: got writes=%0d count=%0d error=%0b expected 2/1/0",
                     log_addr.size() - base, rec_count, error);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        send_str(":0200");
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if (rec_count !== 16'd0 || wr_en !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got count=%0d wr_en=%0b expected 0/0", rec_count, wr_en);
        end
        base = log_addr.size();
        send_str(":02001000ABCD76");
        idle(2);
        checks++;
        if (log_addr.size() - base != 2) begin
            errors++;
            $display("FAIL mid_reset_writes: got %0d writes expected 2", log_addr.size() - base);
        end else begin
            checks++;
            if (log_addr[base] !== 14'h0010 || log_data[base] !== 8'hAB ||
                log_addr[base+1] !== 14'h0011 || log_data[base+1] !== 8'hCD) begin
                errors++;
                $display("FAIL mid_reset_vals: got %h@%h %h@%h expected ab@0010 cd@0011",
                         log_data[base], log_addr[base], log_data[base+1], log_addr[base+1]);
            end
        end
        checks++;
        if (rec_count !== 16'd1) begin
            errors++;
            $display("FAIL mid_reset_count: got %0d expected 1", rec_count);
        end
    endtask

    task automatic test_restart_vs_byte();
        int base;
        base = log_addr.size();
        restart  = 1'b1;
        in_valid = 1'b1;
        in_byte  = ASCII_COLON;
        @(negedge clock);
        restart  = 1'b0;
        in_valid = 1'b0;
        in_byte  = 8'h00;
        send_str("01000000AA55");
        idle(2);
        checks++;
        if (log_addr.size() - base != 0 || error !== 1'b0 || rec_count !== 16'd0) begin
            errors++;
            $display("FAIL restart_wins: got writes=%0d error=%0b count=%0d expected 0/0/0",
                     log_addr.size() - base, error, rec_count);
        end
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_byte  = 8'h00;
        restart  = 1'b0;
        @(negedge clock);
        test_reset();
        test_data_record();
        test_eof();
        test_csum_error();
        test_bad_char();
        test_range();
        test_reset_mid();
        test_restart_vs_byte();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
